// File: rtl/ddr_pkg.sv
// Shared types and helpers for the arrow scheduler.
// LFSR step and lane-code mapping live here so every user agrees on them.
package ddr_pkg;

  localparam int LANE_W       = 4;
  localparam int LFSR_W       = 6;
  localparam int REST_THRESH  = 4;
  localparam int ARROW_MOD    = 10;
  localparam int ARROW_BEAT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [LANE_W-1:0]       lanes;
    logic [ARROW_BEAT_W-1:0] beat;
  } arrow_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] q
  );
    return {q[4:0], q[5] ^ q[4]};
  endfunction

  function automatic logic [LFSR_W-1:0] arrow_code(
    input logic [LFSR_W-1:0] v
  );
    return v % LFSR_W'(ARROW_MOD);
  endfunction

endpackage

// File: rtl/lfsr6.sv
// 6-bit Fibonacci LFSR with seed load and step enable.
// A zero seed would lock the register, so it is loaded as 6'h01.
module lfsr6
  import ddr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (seed == '0) ? LFSR_W'(1) : seed;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= LFSR_W'(1);
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/arrow_scheduler.sv
// Turns beat ticks plus LFSR output into a queued stream of arrow events.
// Build with ARROW_NO_REPEAT_EN to bump a lane that repeats the last pushed one.
module arrow_scheduler
  import ddr_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int NUM_ARROWS = 32,
  parameter int BEAT_W     = ARROW_BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [LFSR_W-1:0] seed,
  input  logic              beat_tick,
  output logic              arrow_valid,
  input  logic              arrow_ready,
  output logic [LANE_W-1:0] arrow_lanes,
  output logic [BEAT_W-1:0] arrow_beat,
  output logic              busy,
  output logic              done,
  output logic              dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_ARROWS + 1);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt, code;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic              dropped_q, dropped_d;
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  arrow_t            mem_q [DEPTH];
  arrow_t            head, wdata;
  logic [LANE_W-1:0] lanes_raw, lanes_sel;
  logic go, flush, all_issued, tick_ok;
  logic is_arrow, empty, full, pop, push, drop;

  assign go         = (state_q == IDLE) && start && !stop;
  assign flush      = go || stop;
  assign all_issued = (issued_q == CW'(NUM_ARROWS));
  assign tick_ok    = (state_q == RUN) && beat_tick
                    && !all_issued && !stop;

  lfsr6 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (go),
    .seed (seed),
    .step (tick_ok),
    .q    (lfsr_q)
  );

  assign lfsr_nxt  = lfsr_next(lfsr_q);
  assign code      = arrow_code(lfsr_nxt);
  assign is_arrow  = code < LFSR_W'(REST_THRESH);
  assign lanes_raw = LANE_W'(1) << code[1:0];

`ifdef ARROW_NO_REPEAT_EN
  logic [LANE_W-1:0] last_q, last_d;

  assign lanes_sel = (lanes_raw == last_q)
                   ? LANE_W'(1) << (code[1:0] + 2'd1)
                   : lanes_raw;

  always_comb begin
    last_d = last_q;
    if (go)        last_d = '0;
    else if (push) last_d = lanes_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= '0;
    else     last_q <= last_d;
  end
`else
  assign lanes_sel = lanes_raw;
`endif

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW])
              && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && arrow_ready;
  // A full FIFO still takes a push when the head leaves that cycle.
  assign push  = tick_ok && is_arrow && (!full || pop);
  assign drop  = tick_ok && is_arrow && full && !pop;

  assign head  = mem_q[rd_q[AW-1:0]];
  assign wdata = '{lanes: lanes_sel,
                   beat:  ARROW_BEAT_W'(beat_q)};

  always_comb begin
    beat_d    = beat_q;
    issued_d  = issued_q;
    dropped_d = dropped_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      if (go) begin
        beat_d    = '0;
        issued_d  = '0;
        dropped_d = 1'b0;
      end
    end else begin
      if (pop)  rd_d = rd_q + (AW+1)'(1);
      if (push) wr_d = wr_q + (AW+1)'(1);
      if (drop) dropped_d = 1'b1;
      if (tick_ok) begin
        beat_d = beat_q + BEAT_W'(1);
        if (is_arrow) issued_d = issued_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q    <= '0;
      issued_q  <= '0;
      dropped_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      beat_q    <= beat_d;
      issued_q  <= issued_d;
      dropped_q <= dropped_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (go) state_d = RUN;
      RUN:   if (stop) state_d = IDLE;
             else if (all_issued) state_d = DRAIN;
      DRAIN: if (stop || empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DRAIN) && empty && !stop;
  end

  assign arrow_valid = !empty;
  assign arrow_lanes = empty ? '0 : head.lanes;
  assign arrow_beat  = empty ? '0 : BEAT_W'(head.beat);
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_arrow_scheduler.sv
// Directed bench for arrow_scheduler, default and NUM_ARROWS=2 instances.
// Expected lanes/beats come from hand-stepping the LFSR from seed 1.
module tb_arrow_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [5:0] seed = '0;
  logic       beat_tick = 1'b0;
  logic       arrow_ready = 1'b0;

  logic       valid, busy, done, dropped;
  logic [3:0] lanes;
  logic [7:0] beat;
  logic       valid2, busy2, done2, dropped2;
  logic [3:0] lanes2;
  logic [7:0] beat2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arrow_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .seed(seed), .beat_tick(beat_tick),
    .arrow_valid(valid), .arrow_ready(arrow_ready),
    .arrow_lanes(lanes), .arrow_beat(beat),
    .busy(busy), .done(done), .dropped(dropped)
  );

  arrow_scheduler #(.NUM_ARROWS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .seed(seed), .beat_tick(beat_tick),
    .arrow_valid(valid2), .arrow_ready(arrow_ready),
    .arrow_lanes(lanes2), .arrow_beat(beat2),
    .busy(busy2), .done(done2), .dropped(dropped2)
  );

`ifdef ARROW_NO_REPEAT_EN
  localparam logic [3:0] BEAT5_LANE = 4'b0001;
`else
  localparam logic [3:0] BEAT5_LANE = 4'b1000;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic song(input logic [5:0] s);
    seed = s;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      beat_tick = 1'b1;
      step();
      beat_tick = 1'b0;
      step();
    end
  endtask

  task automatic pop1();
    arrow_ready = 1'b1;
    step();
    arrow_ready = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  logic [7:0] exp_beat [4];
  logic [3:0] exp_lane [4];
  int ndone;

  initial begin
    step();
    step();
    chk("rst_valid", valid, 0);
    chk("rst_lanes", lanes, 0);
    chk("rst_beat", beat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dropped", dropped, 0);
    rst = 1'b0;
    step();

    // seed 1, five ticks, no consumer
    song(6'd1);
    chk("a_busy", busy, 1);
    ticks(5);
    chk("a_valid", valid, 1);
    chk("a_head0_lanes", lanes, 4'b0100);
    chk("a_head0_beat", beat, 0);
    pop1();
    chk("a_head1_lanes", lanes, 4'b1000);
    chk("a_head1_beat", beat, 4);
    pop1();
    chk("a_empty_valid", valid, 0);
    chk("a_empty_lanes", lanes, 0);
    chk("a_empty_beat", beat, 0);
    chk("a_dropped", dropped, 0);
    halt();

    // seed 0 behaves as seed 1, one-cycle push latency
    song(6'd0);
    beat_tick = 1'b1;
    chk("b_pre_valid", valid, 0);
    step();
    beat_tick = 1'b0;
    chk("b_valid", valid, 1);
    chk("b_lanes", lanes, 4'b0100);
    chk("b_beat", beat, 0);
    halt();

    // tick during the start cycle is ignored
    seed = 6'd1;
    start = 1'b1;
    beat_tick = 1'b1;
    step();
    start = 1'b0;
    beat_tick = 1'b0;
    step();
    chk("g_ign_valid", valid, 0);
    ticks(1);
    chk("g_lanes", lanes, 4'b0100);
    chk("g_beat", beat, 0);
    halt();

    // overflow: four arrows fill, fifth dropped, sixth pushes with pop
    song(6'd1);
    ticks(12);
    chk("c_full_nodrop", dropped, 0);
    ticks(1);
    chk("c_dropped", dropped, 1);
    chk("c_head_kept", beat, 0);
    beat_tick = 1'b1;
    arrow_ready = 1'b1;
    step();
    beat_tick = 1'b0;
    arrow_ready = 1'b0;
    step();
    chk("c_dropped_sticky", dropped, 1);
    exp_beat = '{8'd4, 8'd5, 8'd7, 8'd13};
    exp_lane = '{4'b1000, BEAT5_LANE, 4'b0100, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("c_valid%0d", i), valid, 1);
      chk($sformatf("c_beat%0d", i), beat, exp_beat[i]);
      chk($sformatf("c_lane%0d", i), lanes, exp_lane[i]);
      pop1();
    end
    chk("c_drained", valid, 0);
    halt();

    // NUM_ARROWS=2: done after second arrow popped
    arrow_ready = 1'b1;
    song(6'd1);
    chk("d_busy", busy2, 1);
    ticks(5);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done2) ndone++;
      step();
    end
    chk("d_done_cycles", ndone, 1);
    chk("d_busy_fell", busy2, 0);
    chk("d_main_busy", busy, 1);
    chk("d_main_done", done, 0);
    arrow_ready = 1'b0;
    halt();

    // stop mid-RUN with three queued
    song(6'd1);
    ticks(7);
    chk("e_valid", valid, 1);
    stop = 1'b1;
    chk("e_done_stop", done, 0);
    step();
    stop = 1'b0;
    chk("e_busy", busy, 0);
    chk("e_valid_flush", valid, 0);
    chk("e_lanes_flush", lanes, 0);
    chk("e_done", done, 0);
    step();

    // stop beats start in IDLE
    seed = 6'd1;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("f_stop_wins", busy, 0);

    // reset mid-song
    song(6'd1);
    ticks(1);
    rst = 1'b1;
    step();
    chk("h_rst_busy", busy, 0);
    chk("h_rst_valid", valid, 0);
    chk("h_rst_done", done2, 0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
